// File: rtl/player_health_pkg.sv
// player_health_pkg: shared state encoding and default constants for the player health controller
package player_health_pkg;
  typedef enum logic [1:0] {HS_ALIVE, HS_INVULN, HS_DEAD} health_state_t;
  localparam int DEFAULT_LIVES         = 4;
  localparam int DEFAULT_LIVES_MAX     = 6;
  localparam int DEFAULT_INVULN_FRAMES = 120;
  localparam int DEFAULT_BLINK_HALF    = 8;
  localparam int TIMER_W               = 8;
endpackage

// File: rtl/player_health_frame_timer.sv
// frame_timer: loadable frame down-counter; ports clk/rst, i_load+i_value load, i_tick decrements, o_done flags the tick that reaches zero
module frame_timer
  import player_health_pkg::*;
#(
  parameter int W = TIMER_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_value,
  input  logic         i_tick,
  output logic         o_done
);
  logic [W-1:0] r_cnt;
  always_ff @(posedge clk) begin
    if (rst) r_cnt <= '0;
    else if (i_load) r_cnt <= i_value;
    else if (i_tick && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
  end
  assign o_done = i_tick && (r_cnt == W'(1));
endmodule

// File: rtl/player_health.sv
// player_health: lives/damage FSM merging masked hit channels, with invulnerability blink, bonus lives and game-over
module player_health
  import player_health_pkg::*;
#(
  parameter int                    LIVES_WIDTH   = 3,
  parameter int                    LIVES_INIT    = DEFAULT_LIVES,
  parameter int                    LIVES_MAX     = DEFAULT_LIVES_MAX,
  parameter int                    NUM_HIT_CH    = 4,
  parameter logic [NUM_HIT_CH-1:0] HIT_MASK      = '1,
  parameter int                    INVULN_FRAMES = DEFAULT_INVULN_FRAMES,
  parameter int                    BLINK_HALF    = DEFAULT_BLINK_HALF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   startOfFrame,
  input  logic [NUM_HIT_CH-1:0]  hit,
  input  logic                   extra_life,
  output logic [LIVES_WIDTH-1:0] remaining_lives,
  output logic                   player_damaged,
  output logic                   player_faded,
  output logic                   player_dead,
  output logic                   life_lost
);
  localparam logic [LIVES_WIDTH:0]   L_MAX  = (LIVES_WIDTH + 1)'(LIVES_MAX);
  localparam logic [LIVES_WIDTH-1:0] L_INIT = LIVES_WIDTH'(LIVES_INIT);
  localparam logic [LIVES_WIDTH-1:0] L_ONE  = LIVES_WIDTH'(1);
  localparam logic [TIMER_W-1:0]     INV_LD = TIMER_W'(INVULN_FRAMES);
  localparam logic [TIMER_W-1:0]     BL_LD  = TIMER_W'(BLINK_HALF);
  if (LIVES_INIT == 0 || LIVES_INIT > LIVES_MAX || LIVES_MAX >= 2 ** LIVES_WIDTH) begin : g_bad_lives
    $error("player_health: illegal LIVES_INIT/LIVES_MAX/LIVES_WIDTH combination");
  end
  health_state_t          r_state, w_state_nxt;
  logic [LIVES_WIDTH-1:0] r_lives, w_lives_nxt;
  logic [LIVES_WIDTH:0]   w_sum;
  logic                   r_faded, w_faded_nxt, r_life_lost;
  logic                   w_hit_ok, w_xl_ok, w_fatal, w_enter, w_tick, w_inv_done, w_blink_done;
  assign w_hit_ok = (|(hit & HIT_MASK)) & enable & (r_state == HS_ALIVE);
  assign w_xl_ok  = extra_life & enable & (r_state != HS_DEAD);
  // a bonus life arriving with the last-life hit keeps the player alive
  assign w_fatal  = w_hit_ok & (r_lives == L_ONE) & ~w_xl_ok;
  assign w_enter  = w_hit_ok & ~w_fatal;
  assign w_tick   = startOfFrame & enable & (r_state == HS_INVULN);
  frame_timer #(.W(TIMER_W)) u_invuln (
    .clk    (clk),
    .rst    (reset),
    .i_load (w_enter),
    .i_value(INV_LD),
    .i_tick (w_tick),
    .o_done (w_inv_done)
  );
  // blink reloads itself each half-period and is cleared when invulnerability ends
  frame_timer #(.W(TIMER_W)) u_blink (
    .clk    (clk),
    .rst    (reset),
    .i_load (w_enter | w_inv_done | w_blink_done),
    .i_value(w_inv_done ? '0 : BL_LD),
    .i_tick (w_tick),
    .o_done (w_blink_done)
  );
  always_comb begin
    w_sum       = {1'b0, r_lives} + {{LIVES_WIDTH{1'b0}}, w_xl_ok} - {{LIVES_WIDTH{1'b0}}, w_hit_ok};
    w_lives_nxt = w_fatal ? '0 : (w_sum > L_MAX) ? L_MAX[LIVES_WIDTH-1:0] : w_sum[LIVES_WIDTH-1:0];
    w_state_nxt = w_fatal ? HS_DEAD : w_enter ? HS_INVULN : w_inv_done ? HS_ALIVE : r_state;
    w_faded_nxt = (w_fatal | w_enter) ? 1'b1 : w_inv_done ? 1'b0 : w_blink_done ? ~r_faded : r_faded;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= HS_ALIVE;
      r_lives     <= L_INIT;
      r_faded     <= 1'b0;
      r_life_lost <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_lives     <= w_lives_nxt;
      r_faded     <= w_faded_nxt;
      r_life_lost <= w_hit_ok;
    end
  end
  assign remaining_lives = r_lives;
  assign player_damaged  = (r_state == HS_INVULN);
  assign player_faded    = r_faded;
  assign player_dead     = (r_state == HS_DEAD);
  assign life_lost       = r_life_lost;
endmodule

// File: tb/tb_player_health.sv
// tb_player_health: randomized scoreboard bench for player_health against a frame-count reference model
module tb_player_health;
  localparam int INV = 120, BH = 8, LMAX = 6, LINIT = 4;
  logic       clk = 1'b0, reset = 1'b1, enable = 1'b0, startOfFrame = 1'b0, extra_life = 1'b0;
  logic [3:0] hit = 4'b0;
  logic [2:0] remaining_lives;
  logic       player_damaged, player_faded, player_dead, life_lost;
  always #5 clk = ~clk;
  player_health #(.HIT_MASK(4'b0111)) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .startOfFrame   (startOfFrame),
    .hit            (hit),
    .extra_life     (extra_life),
    .remaining_lives(remaining_lives),
    .player_damaged (player_damaged),
    .player_faded   (player_faded),
    .player_dead    (player_dead),
    .life_lost      (life_lost)
  );
  typedef struct packed {
    logic [2:0] lives;
    logic       dmg;
    logic       fad;
    logic       dead;
    logic       ll;
  } obs_t;
  obs_t q[$];
  int   checks = 0, errors = 0;
  int   m_lives = LINIT, m_mode = 0, m_rem = 0;
  logic m_ll = 1'b0;
  task automatic step(input logic rs, input logic en, input logic sof, input logic [3:0] h, input logic xl);
    logic hv, xv;
    obs_t e;
    @(negedge clk);
    reset = rs; enable = en; startOfFrame = sof; hit = h; extra_life = xl;
    hv = en && ((h & 4'b0111) != 4'b0);
    xv = en && xl;
    if (rs) begin
      m_lives = LINIT; m_mode = 0; m_rem = 0; m_ll = 1'b0;
    end else begin
      m_ll = 1'b0;
      if (m_mode == 0) begin
        if (hv) begin
          m_ll = 1'b1;
          if (m_lives == 1 && !xv) begin
            m_lives = 0; m_mode = 2;
          end else begin
            m_lives = (m_lives - 1 + int'(xv) > LMAX) ? LMAX : m_lives - 1 + int'(xv);
            m_mode = 1; m_rem = INV;
          end
        end else if (xv) m_lives = (m_lives + 1 > LMAX) ? LMAX : m_lives + 1;
      end else if (m_mode == 1) begin
        if (xv) m_lives = (m_lives + 1 > LMAX) ? LMAX : m_lives + 1;
        if (en && sof) begin
          m_rem = m_rem - 1;
          if (m_rem == 0) m_mode = 0;
        end
      end
    end
    e.lives = 3'(m_lives);
    e.dmg   = (m_mode == 1);
    e.dead  = (m_mode == 2);
    e.fad   = (m_mode == 2) ? 1'b1 : (m_mode == 1) ? (((INV - m_rem) / BH) % 2 == 0) : 1'b0;
    e.ll    = m_ll;
    q.push_back(e);
  endtask
  always @(posedge clk) begin
    obs_t e, a;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      a = {remaining_lives, player_damaged, player_faded, player_dead, life_lost};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL outputs t=%0t got lives=%0d dmg=%b fad=%b dead=%b ll=%b required lives=%0d dmg=%b fad=%b dead=%b ll=%b",
                 $time, a.lives, a.dmg, a.fad, a.dead, a.ll, e.lives, e.dmg, e.fad, e.dead, e.ll);
      end
    end
  end
  initial begin
    repeat (2) step(1, 0, 0, 4'b0, 0);
    repeat (50) step(0, 1, 0, 4'b0001, 0);
    repeat (125) step(0, 1, 1, 4'b0, 0);
    repeat (20) step(0, 1, 1, 4'b1000, 0);
    repeat (4) begin
      step(0, 1, 0, 4'b0, 1);
      step(0, 1, 0, 4'b0, 0);
    end
    step(0, 1, 0, 4'b0010, 0);
    repeat (200) step(0, 0, 1, 4'($urandom), 1'($urandom));
    repeat (30) step(0, 1, 1, 4'b0, 0);
    step(1, 1, 0, 4'b0, 0);
    step(0, 1, 0, 4'b0, 0);
    repeat (3) begin
      step(0, 1, 0, 4'b0100, 0);
      repeat (121) step(0, 1, 1, 4'b0, 0);
    end
    step(0, 1, 0, 4'b0001, 1);
    repeat (121) step(0, 1, 1, 4'b0, 0);
    step(0, 1, 0, 4'b0001, 0);
    repeat (20) step(0, 1, 1'($urandom), 4'($urandom), 1'($urandom));
    step(1, 1, 0, 4'b0, 0);
    repeat (4000)
      step($urandom_range(0, 499) == 0, $urandom_range(0, 9) != 0, $urandom_range(0, 3) == 0,
           ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'b0, $urandom_range(0, 31) == 0);
    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
